// File: rtl/sys_control_tx_pkg.sv
// Shared definitions for the sys-control TX return path: FSM encodings and
// the command bytes agreed with the RX-side controller.
package sys_control_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } tx_state_e;

    // Command bytes decoded by the RX controller; kept beside the TX encodings.
    localparam logic [7:0] CMD_AA = 8'hAA;
    localparam logic [7:0] CMD_BB = 8'hBB;
    localparam logic [7:0] CMD_CC = 8'hCC;
    localparam logic [7:0] CMD_DD = 8'hDD;

endpackage

// File: rtl/sys_control_tx.sv
// Serialises RF (1 byte) and ALU (2 byte) results into a byte stream for
// uart_tx, pacing each byte against the UART busy flag.
module sys_control_tx
    import sys_control_tx_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int ALU_MSB_FIRST = 0,
    parameter int BUSY_TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               rf_send_in,
    input  logic [WIDTH-1:0]   rf_send_data_in,
    input  logic               alu_send_in,
    input  logic [2*WIDTH-1:0] alu_send_data_in,
    input  logic               uart_tx_busy_in,
    output logic [WIDTH-1:0]   uart_tx_data_out,
    output logic               uart_tx_data_valid_out,
    output logic               tx_idle_out,
    output logic               overflow_err_out
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    // Handshake: uart_tx_data_valid_out is a one-cycle load strobe, raised
    // only in SEND while busy is low; uart_tx_data_out is held from SEND entry.
    tx_state_e          state, state_nxt;
    logic               rf_full, alu_full;
    logic [WIDTH-1:0]   rf_slot;
    logic [2*WIDTH-1:0] alu_slot;
    logic [WIDTH-1:0]   byte_reg, hi_reg;
    logic [1:0]         count;
    logic [TW-1:0]      tmo_cnt;
    logic               rf_take, alu_take, load_next, send_fire, tmo_inc;

    always_comb begin
        state_nxt = state;
        rf_take   = 1'b0;
        alu_take  = 1'b0;
        load_next = 1'b0;
        send_fire = 1'b0;
        tmo_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rf_full) begin
                    rf_take   = 1'b1;
                    state_nxt = ST_SEND;
                end else if (alu_full) begin
                    alu_take  = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!uart_tx_busy_in) begin
                    send_fire = 1'b1;
                    state_nxt = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                tmo_inc = 1'b1;
                // A UART that never reports busy is treated as having taken the byte.
                if (uart_tx_busy_in || (tmo_cnt == TW'(BUSY_TIMEOUT - 1)))
                    state_nxt = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (!uart_tx_busy_in) begin
                    if (count != 2'd0) begin
                        load_next = 1'b1;
                        state_nxt = ST_SEND;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            rf_full          <= 1'b0;
            alu_full         <= 1'b0;
            rf_slot          <= '0;
            alu_slot         <= '0;
            byte_reg         <= '0;
            hi_reg           <= '0;
            count            <= 2'd0;
            tmo_cnt          <= '0;
            overflow_err_out <= 1'b0;
        end else begin
            state <= state_nxt;

            // The FSM's clear lands first, so a pulse in the same cycle is accepted.
            if (rf_take) rf_full <= 1'b0;
            if (rf_send_in) begin
                if (rf_full && !rf_take) begin
                    overflow_err_out <= 1'b1;
                end else begin
                    rf_slot <= rf_send_data_in;
                    rf_full <= 1'b1;
                end
            end

            if (alu_take) alu_full <= 1'b0;
            if (alu_send_in) begin
                if (alu_full && !alu_take) begin
                    overflow_err_out <= 1'b1;
                end else begin
                    alu_slot <= alu_send_data_in;
                    alu_full <= 1'b1;
                end
            end

            if (rf_take) begin
                byte_reg <= rf_slot;
                count    <= 2'd1;
            end else if (alu_take) begin
                if (ALU_MSB_FIRST != 0) begin
                    byte_reg <= alu_slot[2*WIDTH-1:WIDTH];
                    hi_reg   <= alu_slot[WIDTH-1:0];
                end else begin
                    byte_reg <= alu_slot[WIDTH-1:0];
                    hi_reg   <= alu_slot[2*WIDTH-1:WIDTH];
                end
                count <= 2'd2;
            end else if (load_next) begin
                byte_reg <= hi_reg;
            end

            if (send_fire) begin
                count   <= count - 2'd1;
                tmo_cnt <= '0;
            end else if (tmo_inc) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

    assign uart_tx_data_out       = byte_reg;
    assign uart_tx_data_valid_out = (state == ST_SEND) && !uart_tx_busy_in;
    assign tx_idle_out            = (state == ST_IDLE) && !rf_full && !alu_full;

endmodule

// File: tb/tb_sys_control_tx.sv
// Directed bench for sys_control_tx with a simple UART busy model.
module tb_sys_control_tx;

    localparam int WIDTH = 8;
    localparam int TMO   = 15;
    localparam int FRAME = 10;

    logic               clk;
    logic               reset_n;
    logic               rf_send_in;
    logic [WIDTH-1:0]   rf_send_data_in;
    logic               alu_send_in;
    logic [2*WIDTH-1:0] alu_send_data_in;
    logic               uart_tx_busy_in;
    logic [WIDTH-1:0]   uart_tx_data_out;
    logic               uart_tx_data_valid_out;
    logic               tx_idle_out;
    logic               overflow_err_out;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [WIDTH-1:0] got_q[$];
    int               got_cyc[$];
    logic [WIDTH-1:0] exp_q[$];
    bit               uart_auto = 1'b1;
    int               busy_left = 0;
    bit               prev_v    = 1'b0;

    sys_control_tx #(
        .WIDTH(WIDTH), .ALU_MSB_FIRST(0), .BUSY_TIMEOUT(TMO)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .rf_send_in             (rf_send_in),
        .rf_send_data_in        (rf_send_data_in),
        .alu_send_in            (alu_send_in),
        .alu_send_data_in       (alu_send_data_in),
        .uart_tx_busy_in        (uart_tx_busy_in),
        .uart_tx_data_out       (uart_tx_data_out),
        .uart_tx_data_valid_out (uart_tx_data_valid_out),
        .tx_idle_out            (tx_idle_out),
        .overflow_err_out       (overflow_err_out)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor + UART model: busy rises at the strobe's falling edge, held FRAME cycles.
    always @(negedge clk) begin
        logic             v;
        logic [WIDTH-1:0] d;
        v = uart_tx_data_valid_out;
        d = uart_tx_data_out;
        if (v) begin
            checks++;
            if (prev_v) begin
                errors++;
                $display("FAIL valid_consecutive: valid=1 two cycles in a row at cycle %0d", cyc);
            end
            got_q.push_back(d);
            got_cyc.push_back(cyc);
        end
        prev_v = v;
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) uart_tx_busy_in = 1'b0;
        end
        if (v && uart_auto) begin
            uart_tx_busy_in = 1'b1;
            busy_left       = FRAME;
        end
    end

    // Driver tasks
    task automatic pulse_rf(input logic [WIDTH-1:0] d, output int c);
        @(negedge clk);
        rf_send_in = 1'b1; rf_send_data_in = d; c = cyc;
        @(negedge clk);
        rf_send_in = 1'b0;
    endtask

    task automatic pulse_alu(input logic [2*WIDTH-1:0] d, output int c);
        @(negedge clk);
        alu_send_in = 1'b1; alu_send_data_in = d; c = cyc;
        @(negedge clk);
        alu_send_in = 1'b0;
    endtask

    task automatic pulse_both(input logic [WIDTH-1:0] r, input logic [2*WIDTH-1:0] a);
        @(negedge clk);
        rf_send_in = 1'b1; rf_send_data_in = r;
        alu_send_in = 1'b1; alu_send_data_in = a;
        @(negedge clk);
        rf_send_in = 1'b0; alu_send_in = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int n = 0;
        while (!(tx_idle_out && !uart_tx_busy_in) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (!(tx_idle_out && !uart_tx_busy_in)) begin
            errors++;
            $display("FAIL %s_idle_timeout: tx_idle_out=%0b busy=%0b after %0d cycles, required idle=1",
                     name, tx_idle_out, uart_tx_busy_in, max_cyc);
        end
    endtask

    // Tests
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (uart_tx_data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", uart_tx_data_out); end
        if (uart_tx_data_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", uart_tx_data_valid_out); end
        if (tx_idle_out !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", tx_idle_out); end
        if (overflow_err_out !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow_err_out); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (tx_idle_out !== 1'b1 || uart_tx_data_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: idle=%b valid=%b want idle=1 valid=0", tx_idle_out, uart_tx_data_valid_out);
        end
    endtask

    task automatic test_rf_single();
        int c;
        got_q.delete(); got_cyc.delete();
        pulse_rf(8'h5A, c);
        wait_idle("rf_single", 60);
        checks += 4;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL rf_count: got %0d strobes want 1", got_q.size());
        end else begin
            if (got_q[0] !== 8'h5A) begin errors++; $display("FAIL rf_data: got %h want 5a", got_q[0]); end
            if (got_cyc[0] != c + 2) begin errors++; $display("FAIL rf_latency: strobe at %0d want %0d", got_cyc[0], c + 2); end
        end
        if (tx_idle_out !== 1'b1) begin errors++; $display("FAIL rf_idle: got %b want 1", tx_idle_out); end
        if (overflow_err_out !== 1'b0) begin errors++; $display("FAIL rf_ovf: got %b want 0", overflow_err_out); end
    endtask

    task automatic test_alu_lsb_first();
        int c;
        got_q.delete(); got_cyc.delete();
        exp_q = '{8'hEF, 8'hBE};
        pulse_alu(16'hBEEF, c);
        wait_idle("alu", 80);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL alu_count: got %0d strobes want %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL alu_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
            end
            checks += 2;
            if (got_cyc[0] != c + 2) begin errors++; $display("FAIL alu_latency: strobe at %0d want %0d", got_cyc[0], c + 2); end
            if (got_cyc[1] - got_cyc[0] <= FRAME) begin
                errors++; $display("FAIL alu_pacing: gap %0d cycles want > %0d", got_cyc[1] - got_cyc[0], FRAME);
            end
        end
    endtask

    task automatic test_back_to_back();
        got_q.delete(); got_cyc.delete();
        exp_q = '{8'h11, 8'h33, 8'h22};
        pulse_both(8'h11, 16'h2233);
        wait_idle("b2b", 120);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL b2b_count: got %0d strobes want %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
        checks++;
        if (overflow_err_out !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b want 0", overflow_err_out); end
    endtask

    task automatic test_overflow();
        int c;
        got_q.delete(); got_cyc.delete();
        exp_q = '{8'h34, 8'h12, 8'h66};
        pulse_alu(16'h1234, c);
        repeat (3) @(negedge clk);
        pulse_rf(8'h66, c);
        pulse_rf(8'h77, c);
        checks++;
        if (overflow_err_out !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow_err_out); end
        wait_idle("ovf", 150);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL ovf_count: got %0d strobes want %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
        checks++;
        if (overflow_err_out !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow_err_out); end
    endtask

    task automatic test_busy_timeout();
        int c;
        int n = 0;
        uart_auto = 1'b0;
        got_q.delete(); got_cyc.delete();
        exp_q = '{8'hCD, 8'hAB};
        pulse_alu(16'hABCD, c);
        while (got_q.size() < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (got_q.size() != 2) begin
            errors++; $display("FAIL tmo_deadlock: got %0d strobes want 2", got_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL tmo_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
            end
            checks++;
            if (got_cyc[1] - got_cyc[0] < TMO || got_cyc[1] - got_cyc[0] > TMO + 3) begin
                errors++; $display("FAIL tmo_gap: gap %0d cycles want %0d..%0d", got_cyc[1] - got_cyc[0], TMO, TMO + 3);
            end
        end
        wait_idle("tmo", 40);
        uart_auto = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        int c;
        int n = 0;
        got_q.delete(); got_cyc.delete();
        pulse_alu(16'h0F0E, c);
        while (got_q.size() < 1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'h0E) begin
            errors++; $display("FAIL rst_first_byte: got %0d strobes, want one carrying 0e", got_q.size());
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks += 4;
        if (uart_tx_data_out !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h want 00", uart_tx_data_out); end
        if (uart_tx_data_valid_out !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", uart_tx_data_valid_out); end
        if (tx_idle_out !== 1'b1) begin errors++; $display("FAIL rst_mid_idle: got %b want 1", tx_idle_out); end
        if (overflow_err_out !== 1'b0) begin errors++; $display("FAIL rst_mid_ovf: got %b want 0", overflow_err_out); end
        @(negedge clk);
        reset_n = 1'b1;
        got_q.delete(); got_cyc.delete();
        repeat (40) @(negedge clk);
        checks += 2;
        if (got_q.size() != 0) begin errors++; $display("FAIL rst_no_resume: got %0d strobes want 0", got_q.size()); end
        if (tx_idle_out !== 1'b1) begin errors++; $display("FAIL rst_idle_after: got %b want 1", tx_idle_out); end
    endtask

    initial begin
        reset_n          = 1'b0;
        rf_send_in       = 1'b0;
        rf_send_data_in  = '0;
        alu_send_in      = 1'b0;
        alu_send_data_in = '0;
        uart_tx_busy_in  = 1'b0;
        test_reset();
        test_rf_single();
        test_alu_lsb_first();
        test_back_to_back();
        test_overflow();
        test_busy_timeout();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
